// File: rtl/mem_access_ctrl_if.sv
// Request/grant/memory bus bundle for mem_access_ctrl.
// The controller takes the slave view; requesters and memory take the master view.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_done;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_done;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_done, d_gnt, d_done, rdata,
             mem_addr, mem_wdata, mem_re, mem_we, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_done, d_gnt, d_done, rdata,
             mem_addr, mem_wdata, mem_re, mem_we, busy
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Two-port (fetch, load/store) sequencer for the single-ported data memory and MDR.
// Define MEM_CTRL_RR_EN for round-robin arbitration; otherwise data port has fixed priority.
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic               clock,
   input  logic               rst,
   mem_access_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              own_d_q, own_d_d;   // 1 = data port owns the transaction
   logic [DATA_W-1:0] mdr_q, mdr_d;

   logic pick_d, pick_if;
   logic gnt_d, gnt_if;

`ifdef MEM_CTRL_RR_EN
   logic rr_last_q, rr_last_d;   // 1 = data port was granted last

   always_comb begin
      pick_d  = 1'b0;
      pick_if = 1'b0;
      if (bus.d_req && bus.if_req) begin
         pick_d  = !rr_last_q;
         pick_if = rr_last_q;
      end else begin
         pick_d  = bus.d_req;
         pick_if = bus.if_req;
      end
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt_d)  rr_last_d = 1'b1;
      if (gnt_if) rr_last_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (rst) rr_last_q <= 1'b0;
      else     rr_last_q <= rr_last_d;
   end
`else
   always_comb begin
      pick_d  = bus.d_req;
      pick_if = bus.if_req && !bus.d_req;
   end
`endif

   // Grants are Mealy outputs of IDLE, suppressed while reset is held.
   assign gnt_d  = (state_q == S_IDLE) && !rst && pick_d;
   assign gnt_if = (state_q == S_IDLE) && !rst && pick_if;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      own_d_d = own_d_q;
      mdr_d   = mdr_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_d) begin
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               we_d    = bus.d_we;
               own_d_d = 1'b1;
               state_d = S_ACCESS;
            end else if (gnt_if) begin
               addr_d  = bus.if_addr;
               we_d    = 1'b0;
               own_d_d = 1'b0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (we_q) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = LAT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Counter runs LAT..1, so WAIT spans exactly MEM_LAT cycles.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               mdr_d   = bus.mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         own_d_q <= 1'b0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         own_d_q <= own_d_d;
         mdr_q   <= mdr_d;
      end
   end

   assign bus.d_gnt     = gnt_d;
   assign bus.if_gnt    = gnt_if;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_re    = (state_q == S_ACCESS) && !we_q;
   assign bus.mem_we    = (state_q == S_ACCESS) && we_q;
   assign bus.d_done    = (state_q == S_DONE) && own_d_q;
   assign bus.if_done   = (state_q == S_DONE) && !own_d_q;
   assign bus.rdata     = mdr_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic rst1, rst3;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clock (clk),
      .rst   (rst1),
      .bus   (bus1.slave)
   );

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
      .clock (clk),
      .rst   (rst3),
      .bus   (bus3.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic exp_d, seen, seen_d;

      rst1 = 1'b1; rst3 = 1'b1;
      bus1.if_req = 1'b1; bus1.if_addr = 32'h40;
      bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h80; bus1.d_wdata = 32'h12345678;
      bus1.mem_rdata = 32'h0;
      bus3.if_req = 1'b0; bus3.if_addr = 32'h0;
      bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = 32'h0; bus3.d_wdata = 32'h0;
      bus3.mem_rdata = 32'h0;

      // reset with both requests high
      tick(); @(negedge clk);
      chk1("rst_d_gnt", bus1.d_gnt, 1'b0);
      chk1("rst_if_gnt", bus1.if_gnt, 1'b0);
      chk1("rst_busy", bus1.busy, 1'b0);
      chk1("rst_mem_re", bus1.mem_re, 1'b0);
      chk1("rst_mem_we", bus1.mem_we, 1'b0);
      chk1("rst_done", bus1.d_done | bus1.if_done, 1'b0);
      chk32("rst_rdata", bus1.rdata, 32'h0);
      chk32("rst_mem_addr", bus1.mem_addr, 32'h0);
      chk32("rst_mem_wdata", bus1.mem_wdata, 32'h0);
      tick(); @(negedge clk);
      chk1("rst2_d_gnt", bus1.d_gnt, 1'b0);
      chk1("rst2_if_gnt", bus1.if_gnt, 1'b0);

      // first grant goes to data port: store 0x12345678 -> 0x80
      tick(); rst1 = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      chk1("first_d_gnt", bus1.d_gnt, 1'b1);
      chk1("first_if_gnt", bus1.if_gnt, 1'b0);
      chk1("first_busy", bus1.busy, 1'b0);
      tick();
      bus1.d_req = 1'b0; bus1.if_req = 1'b0;
      bus1.d_addr = 32'hFFF; bus1.d_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk1("st_mem_we", bus1.mem_we, 1'b1);
      chk1("st_mem_re", bus1.mem_re, 1'b0);
      chk32("st_mem_addr", bus1.mem_addr, 32'h80);
      chk32("st_mem_wdata", bus1.mem_wdata, 32'h12345678);
      chk1("st_busy", bus1.busy, 1'b1);
      chk1("st_early_done", bus1.d_done, 1'b0);
      tick(); @(negedge clk);
      chk1("st_d_done", bus1.d_done, 1'b1);
      chk1("st_if_done", bus1.if_done, 1'b0);
      chk1("st_we_off", bus1.mem_we, 1'b0);
      chk32("st_rdata", bus1.rdata, 32'h0);
      tick(); @(negedge clk);
      chk1("st_done_off", bus1.d_done, 1'b0);
      chk1("st_idle_busy", bus1.busy, 1'b0);
      chk32("st_hold_addr", bus1.mem_addr, 32'h80);

      // fetch read, MEM_LAT=1
      tick(); bus1.if_req = 1'b1; bus1.if_addr = 32'h40;
      @(negedge clk);
      chk1("f_if_gnt", bus1.if_gnt, 1'b1);
      chk1("f_d_gnt", bus1.d_gnt, 1'b0);
      tick(); bus1.if_req = 1'b0; bus1.if_addr = 32'h99; bus1.mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      chk1("f_mem_re", bus1.mem_re, 1'b1);
      chk1("f_mem_we", bus1.mem_we, 1'b0);
      chk32("f_mem_addr", bus1.mem_addr, 32'h40);
      tick(); bus1.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk1("f_wait_re", bus1.mem_re, 1'b0);
      chk1("f_wait_done", bus1.if_done, 1'b0);
      chk32("f_wait_rdata", bus1.rdata, 32'h0);
      tick(); bus1.mem_rdata = 32'h11111111;
      @(negedge clk);
      chk1("f_if_done", bus1.if_done, 1'b1);
      chk1("f_d_done", bus1.d_done, 1'b0);
      chk32("f_rdata", bus1.rdata, 32'hDEADBEEF);
      tick(); @(negedge clk);
      chk1("f_done_off", bus1.if_done, 1'b0);
      chk1("f_idle_busy", bus1.busy, 1'b0);
      chk32("f_rdata_hold", bus1.rdata, 32'hDEADBEEF);

      // contention: both ports request for 4 transactions (last grant was fetch)
      tick();
      bus1.if_req = 1'b1; bus1.if_addr = 32'h44;
      bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h84; bus1.d_wdata = 32'hA5A5A5A5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
`ifdef MEM_CTRL_RR_EN
         exp_d = (i % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         chk1($sformatf("cont%0d_d_gnt", i), bus1.d_gnt, exp_d);
         chk1($sformatf("cont%0d_if_gnt", i), bus1.if_gnt, !exp_d);
         seen = 1'b0; seen_d = 1'b0;
         for (int k = 0; k < 8 && !seen; k++) begin
            tick(); @(negedge clk);
            if (bus1.d_done || bus1.if_done) begin
               seen = 1'b1;
               seen_d = bus1.d_done;
            end
         end
         chk1($sformatf("cont%0d_done", i), seen, 1'b1);
         chk1($sformatf("cont%0d_owner", i), seen_d, exp_d);
         tick();
      end
      bus1.if_req = 1'b0; bus1.d_req = 1'b0;

      // MEM_LAT=3 load with garbage on mem_rdata before the capture cycle
      tick(); bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h100;
      @(negedge clk);
      chk1("l3_d_gnt", bus3.d_gnt, 1'b1);
      tick(); bus3.d_req = 1'b0; bus3.d_addr = 32'h0; bus3.mem_rdata = 32'hAAAA0001;
      @(negedge clk);
      chk1("l3_mem_re", bus3.mem_re, 1'b1);
      chk32("l3_mem_addr", bus3.mem_addr, 32'h100);
      tick(); bus3.mem_rdata = 32'hAAAA0002;
      @(negedge clk);
      chk32("l3_c2_rdata", bus3.rdata, 32'h0);
      chk1("l3_c2_re", bus3.mem_re, 1'b0);
      tick(); bus3.mem_rdata = 32'hAAAA0003;
      @(negedge clk);
      chk32("l3_c3_rdata", bus3.rdata, 32'h0);
      chk1("l3_c3_done", bus3.d_done, 1'b0);
      tick(); bus3.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk32("l3_c4_rdata", bus3.rdata, 32'h0);
      chk1("l3_c4_done", bus3.d_done, 1'b0);
      tick(); bus3.mem_rdata = 32'hAAAA0005;
      @(negedge clk);
      chk1("l3_d_done", bus3.d_done, 1'b1);
      chk32("l3_rdata", bus3.rdata, 32'hCAFEF00D);
      tick(); @(negedge clk);
      chk1("l3_done_off", bus3.d_done, 1'b0);
      chk1("l3_idle_busy", bus3.busy, 1'b0);

      // reset in the middle of WAIT
      tick(); bus3.d_req = 1'b1; bus3.d_addr = 32'h200;
      @(negedge clk);
      chk1("rw_d_gnt", bus3.d_gnt, 1'b1);
      tick(); bus3.d_req = 1'b0;
      tick();
      tick(); rst3 = 1'b1; bus3.mem_rdata = 32'h55555555;
      @(negedge clk);
      chk1("rw_c3_done", bus3.d_done, 1'b0);
      tick(); rst3 = 1'b0;
      @(negedge clk);
      chk1("rw_busy", bus3.busy, 1'b0);
      chk1("rw_done", bus3.d_done, 1'b0);
      chk1("rw_re", bus3.mem_re, 1'b0);
      chk32("rw_rdata", bus3.rdata, 32'h0);
      tick(); @(negedge clk);
      chk1("rw_done2", bus3.d_done, 1'b0);

      // next request after the abandoned one completes normally
      tick(); bus3.d_req = 1'b1; bus3.d_addr = 32'h300;
      @(negedge clk);
      chk1("rn_d_gnt", bus3.d_gnt, 1'b1);
      tick(); bus3.d_req = 1'b0;
      @(negedge clk);
      chk32("rn_mem_addr", bus3.mem_addr, 32'h300);
      tick(); tick(); tick(); bus3.mem_rdata = 32'h00000077;
      tick(); bus3.mem_rdata = 32'h0;
      @(negedge clk);
      chk1("rn_d_done", bus3.d_done, 1'b1);
      chk32("rn_rdata", bus3.rdata, 32'h00000077);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
